// File: rtl/nios2_dbg_pkg.sv
// nios2_dbg_pkg: shared defaults for the Nios II debug command synchroniser.
//   DBG_DATA_W       default width of the shift-register image / jdo
//   DBG_IR_W         default instruction-register width (2**IR_W channels)
//   DBG_SYNC_STAGES  default synchroniser depth (minimum 2)
//   DBG_ACT_BIT      action-bit index for the default width
//   act_bit()        action-bit index for any data width
package nios2_dbg_pkg;
    localparam int DBG_DATA_W      = 38;
    localparam int DBG_IR_W        = 2;
    localparam int DBG_SYNC_STAGES = 2;
    localparam int DBG_ACT_BIT     = DBG_DATA_W - 1;
    function automatic int act_bit(input int data_w);
        return data_w - 1;
    endfunction
endpackage

// File: rtl/nios2_dbg_sync_edge.sv
// nios2_dbg_sync_edge: synchronises a tck-domain level into clk and emits a
// one-cycle pulse on each rising edge of the synchronised level.
//   clk      system clock
//   reset    asynchronous active-high reset
//   i_async  level from the tck domain
//   o_pulse  one-cycle pulse per synchronised rising edge
// SYNC_STAGES must be at least 2.
module nios2_dbg_sync_edge
    import nios2_dbg_pkg::*;
#(
    parameter int SYNC_STAGES = DBG_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_pulse
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev_low;

    // r_fill marks when the synchroniser holds genuine post-reset samples; the
    // edge detector only arms after such a sample is seen low, so a level that
    // is already high when reset releases never produces a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync     <= '0;
            r_fill     <= '0;
            r_prev_low <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev_low <= r_fill[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STAGES-1] & r_prev_low;
endmodule

// File: rtl/nios2_debug_cmd_sync.sv
// nios2_debug_cmd_sync: moves JTAG debug commands from the tck domain into clk
// with a valid/ready handshake and per-channel action pulses.
//   clk, reset               system clock, asynchronous active-high reset
//   sr, ir_in                shift-register image and instruction register (tck domain)
//   e1dr_async, uir_async    exit1-DR and update-IR levels (tck domain)
//   cmd_ready, overrun_clr   consumer accept, overrun clear
//   jdo, cmd_valid, cmd_ch   pending command data, valid flag, channel
//   take_action/no_action    one-hot one-cycle pulse for the accepted command
//   overrun, parity_err      sticky drop flag, one-cycle parity failure pulse
// Optional feature: define NIOS2_DBG_CMD_PARITY_EN to reject captures whose sr
// has odd parity.
module nios2_debug_cmd_sync
    import nios2_dbg_pkg::*;
#(
    parameter int DATA_W      = DBG_DATA_W,
    parameter int IR_W        = DBG_IR_W,
    parameter int SYNC_STAGES = DBG_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    sr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic                 e1dr_async,
    input  logic                 uir_async,
    input  logic                 cmd_ready,
    input  logic                 overrun_clr,
    output logic [DATA_W-1:0]    jdo,
    output logic                 cmd_valid,
    output logic [IR_W-1:0]      cmd_ch,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int NCH = 2**IR_W;
    localparam int ACT = act_bit(DATA_W);

    logic              w_dr_pulse;
    logic              w_ir_pulse;
    logic              w_cap;
    logic              w_hs;
    logic              w_accept;
    logic              w_drop;
    logic [NCH-1:0]    w_onehot;
    logic [IR_W-1:0]   r_ir_q;
    logic [DATA_W-1:0] r_jdo;
    logic              r_cmd_valid;
    logic [IR_W-1:0]   r_cmd_ch;
    logic [NCH-1:0]    r_take_action;
    logic [NCH-1:0]    r_take_no_action;
    logic              r_overrun;

    nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dr_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (e1dr_async),
        .o_pulse (w_dr_pulse)
    );

    nios2_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ir_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (uir_async),
        .o_pulse (w_ir_pulse)
    );

`ifdef NIOS2_DBG_CMD_PARITY_EN
    logic w_par_fail;
    logic r_parity_err;
    assign w_par_fail = w_dr_pulse & (^sr);
    assign w_cap      = w_dr_pulse & ~(^sr);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_parity_err <= 1'b0;
        else       r_parity_err <= w_par_fail;
    end
    assign parity_err = r_parity_err;
`else
    assign w_cap      = w_dr_pulse;
    assign parity_err = 1'b0;
`endif

    // A capture is taken when the slot is empty or being emptied this edge.
    assign w_hs     = r_cmd_valid & cmd_ready;
    assign w_accept = w_cap & (~r_cmd_valid | w_hs);
    assign w_drop   = w_cap & r_cmd_valid & ~cmd_ready;
    assign w_onehot = {{(NCH-1){1'b0}}, 1'b1} << r_cmd_ch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir_q           <= '0;
            r_jdo            <= '0;
            r_cmd_valid      <= 1'b0;
            r_cmd_ch         <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_overrun        <= 1'b0;
        end else begin
            if (w_ir_pulse) r_ir_q <= ir_in;
            if (w_accept) begin
                r_jdo    <= sr;
                r_cmd_ch <= r_ir_q;
            end
            r_cmd_valid      <= w_accept | (r_cmd_valid & ~w_hs);
            r_take_action    <= (w_hs & r_jdo[ACT])  ? w_onehot : '0;
            r_take_no_action <= (w_hs & ~r_jdo[ACT]) ? w_onehot : '0;
            r_overrun        <= w_drop | (r_overrun & ~overrun_clr);
        end
    end

    assign jdo            = r_jdo;
    assign cmd_valid      = r_cmd_valid;
    assign cmd_ch         = r_cmd_ch;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign overrun        = r_overrun;
endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// tb_nios2_debug_cmd_sync: directed scenarios plus a randomized run against a
// transaction-level model of the debug command synchroniser.
module tb_nios2_debug_cmd_sync;
    localparam int SS = 2;
`ifdef NIOS2_DBG_CMD_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] sr = '0;
    logic [1:0]  ir_in = '0;
    logic        e1dr_async = 1'b0;
    logic        uir_async = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic [37:0] jdo;
    logic        cmd_valid;
    logic [1:0]  cmd_ch;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        overrun;
    logic        parity_err;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    int dr_edge = -1;
    int ir_edge = -1;

    // model state: one pending-command slot, current channel, sticky overrun
    logic        m_valid;
    logic [37:0] m_jdo;
    logic [1:0]  m_ch;
    logic [1:0]  m_ir;
    logic        m_ov;
    logic [3:0]  e_act;
    logic [3:0]  e_nact;
    logic        e_perr;

    nios2_debug_cmd_sync dut (
        .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in),
        .e1dr_async(e1dr_async), .uir_async(uir_async),
        .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
        .jdo(jdo), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .take_action(take_action), .take_no_action(take_no_action),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    function automatic void mreset();
        m_valid = 0; m_jdo = '0; m_ch = '0; m_ir = '0; m_ov = 0;
        e_act = '0; e_nact = '0; e_perr = 0;
        dr_edge = -1; ir_edge = -1;
    endfunction

    // One clock edge of the command slot: a handshake retires the pending
    // command into a pulse, a capture fills the slot if it is free after the
    // handshake, otherwise it is dropped.
    function automatic void mstep();
        logic hs, was, drop, bad;
        hs = m_valid && cmd_ready;
        was = m_valid;
        drop = 0;
        e_act = '0; e_nact = '0; e_perr = 0;
        if (hs) begin
            if (m_jdo[37]) e_act[m_ch] = 1'b1;
            else           e_nact[m_ch] = 1'b1;
            m_valid = 0;
        end
        if (cyc == dr_edge) begin
            bad = PAR && (^sr);
            if (bad) e_perr = 1;
            else if (!was || hs) begin
                m_valid = 1; m_jdo = sr; m_ch = m_ir;
            end else drop = 1;
        end
        m_ov = drop || (m_ov && !overrun_clr);
        if (cyc == ir_edge) m_ir = ir_in;
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) mreset(); else mstep();
        @(negedge clk);
    endtask

    function automatic logic [37:0] fixp(input logic [37:0] d);
        logic [37:0] r;
        r = d;
        r[0] = ^d[37:1];
        return r;
    endfunction

    // first sampling edge is cyc+1; capture lands SS edges later
    task automatic raise_dr(input logic [37:0] d);
        sr = d; e1dr_async = 1; dr_edge = cyc + SS + 1;
    endtask

    task automatic strobe_ir(input logic [1:0] ch);
        ir_in = ch; uir_async = 1; ir_edge = cyc + SS + 1;
        repeat (4) tick();
        uir_async = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        mreset();
        reset = 1;
        repeat (3) tick();
        reset = 0;
        repeat (4) tick();
        n_run++;
        if ({cmd_valid, jdo, cmd_ch, take_action, take_no_action, overrun, parity_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state valid=%b jdo=%h ch=%0d act=%b nact=%b ov=%b perr=%b required all 0",
                     cmd_valid, jdo, cmd_ch, take_action, take_no_action, overrun, parity_err);
        end
    endtask

    task automatic test_action();
        logic [37:0] d;
        d = fixp({1'b1, 37'h0a5a5a5a5});
        strobe_ir(2'd2);
        cmd_ready = 1;
        raise_dr(d);
        tick();
        n_run++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL act_lat1 cmd_valid=%b required 0", cmd_valid); end
        tick();
        n_run++;
        if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL act_lat2 cmd_valid=%b required 0", cmd_valid); end
        tick();
        n_run++;
        if (cmd_valid !== 1'b1 || jdo !== d || cmd_ch !== 2'd2) begin
            n_fail++; $display("FAIL act_lat3 valid=%b jdo=%h ch=%0d required 1 %h 2", cmd_valid, jdo, cmd_ch, d);
        end
        tick();
        n_run++;
        if (take_action !== 4'b0100 || take_no_action !== 4'b0000 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL act_pulse act=%b nact=%b valid=%b required 0100 0000 0", take_action, take_no_action, cmd_valid);
        end
        e1dr_async = 0;
        cmd_ready = 0;
        tick();
        n_run++;
        if (take_action !== 4'b0000) begin n_fail++; $display("FAIL act_once act=%b required 0000", take_action); end
        repeat (3) tick();
    endtask

    task automatic test_no_action();
        logic [37:0] d;
        d = fixp({1'b0, 37'h1234567});
        strobe_ir(2'd1);
        raise_dr(d);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            if (i == 1) e1dr_async = 0;
            tick();
            n_run++;
            if (cmd_valid !== 1'b1 || jdo !== d || (take_action | take_no_action) !== 4'b0) begin
                n_fail++; $display("FAIL hold_%0d valid=%b jdo=%h pulses=%b required 1 %h 0000", i, cmd_valid, jdo, take_action | take_no_action, d);
            end
        end
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        n_run++;
        if (take_no_action !== 4'b0010 || take_action !== 4'b0000 || cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL noact_pulse nact=%b act=%b valid=%b required 0010 0000 0", take_no_action, take_action, cmd_valid);
        end
        tick();
        n_run++;
        if (take_no_action !== 4'b0000) begin n_fail++; $display("FAIL noact_once nact=%b required 0000", take_no_action); end
    endtask

    task automatic test_overrun();
        logic [37:0] d1, d2, d3;
        d1 = fixp(38'h2_1111_1111);
        d2 = fixp(38'h3_2222_2222);
        d3 = fixp(38'h0_3333_3333);
        raise_dr(d1); repeat (4) tick(); e1dr_async = 0; repeat (3) tick();
        raise_dr(d2); repeat (4) tick(); e1dr_async = 0; repeat (3) tick();
        n_run++;
        if (jdo !== d1 || overrun !== 1'b1 || cmd_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovr_drop jdo=%h ov=%b valid=%b required %h 1 1", jdo, overrun, cmd_valid, d1);
        end
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        n_run++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr ov=%b required 0", overrun); end
        raise_dr(d3);
        overrun_clr = 1;
        repeat (3) tick();
        n_run++;
        if (overrun !== 1'b1 || jdo !== d1) begin
            n_fail++; $display("FAIL ovr_set_wins ov=%b jdo=%h required 1 %h", overrun, jdo, d1);
        end
        tick();
        overrun_clr = 0;
        e1dr_async = 0;
        n_run++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr2 ov=%b required 0", overrun); end
        repeat (3) tick();
        cmd_ready = 1; tick(); cmd_ready = 0; tick();
    endtask

    task automatic test_aligned();
        logic [37:0] d1, d2;
        d1 = fixp({1'b1, 37'h0_7777_0001});
        d2 = fixp({1'b0, 37'h0_8888_0002});
        raise_dr(d1); repeat (4) tick(); e1dr_async = 0; repeat (3) tick();
        raise_dr(d2);
        repeat (2) tick();
        cmd_ready = 1;
        tick();
        cmd_ready = 0;
        e1dr_async = 0;
        n_run++;
        if (cmd_valid !== 1'b1 || jdo !== d2 || take_action !== 4'b0010 || take_no_action !== 4'b0000) begin
            n_fail++; $display("FAIL aligned valid=%b jdo=%h act=%b nact=%b required 1 %h 0010 0000", cmd_valid, jdo, take_action, take_no_action, d2);
        end
        tick();
        n_run++;
        if ((take_action | take_no_action) !== 4'b0 || cmd_valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL aligned_once pulses=%b valid=%b ov=%b required 0000 1 0", take_action | take_no_action, cmd_valid, overrun);
        end
        repeat (2) tick();
        cmd_ready = 1; tick(); cmd_ready = 0;
        n_run++;
        if (take_no_action !== 4'b0010) begin n_fail++; $display("FAIL aligned_new nact=%b required 0010", take_no_action); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [37:0] d;
        d = fixp(38'h1_5555_aaaa);
        raise_dr(d);
        repeat (4) tick();
        reset = 1;
        #1;
        n_run++;
        if ({cmd_valid, jdo, cmd_ch, take_action, take_no_action, overrun, parity_err} !== '0) begin
            n_fail++; $display("FAIL reset_mid valid=%b jdo=%h ch=%0d ov=%b required all 0", cmd_valid, jdo, cmd_ch, overrun);
        end
        @(negedge clk);
        repeat (2) tick();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_run++;
            if (cmd_valid !== 1'b0 || (take_action | take_no_action) !== 4'b0) begin
                n_fail++; $display("FAIL reset_held_%0d valid=%b pulses=%b required 0 0000", i, cmd_valid, take_action | take_no_action);
            end
        end
        e1dr_async = 0;
        repeat (3) tick();
        raise_dr(d);
        repeat (3) tick();
        n_run++;
        if (cmd_valid !== 1'b1 || jdo !== d || cmd_ch !== 2'd0) begin
            n_fail++; $display("FAIL reset_retoggle valid=%b jdo=%h ch=%0d required 1 %h 0", cmd_valid, jdo, cmd_ch, d);
        end
        tick(); e1dr_async = 0; repeat (3) tick();
        cmd_ready = 1; tick(); cmd_ready = 0; tick();
    endtask

    task automatic test_parity();
        raise_dr(38'h1);
        repeat (3) tick();
        n_run++;
`ifdef NIOS2_DBG_CMD_PARITY_EN
        if (parity_err !== 1'b1 || cmd_valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++; $display("FAIL parity_odd perr=%b valid=%b ov=%b required 1 0 0", parity_err, cmd_valid, overrun);
        end
`else
        if (parity_err !== 1'b0 || cmd_valid !== 1'b1 || jdo !== 38'h1) begin
            n_fail++; $display("FAIL parity_off perr=%b valid=%b jdo=%h required 0 1 1", parity_err, cmd_valid, jdo);
        end
`endif
        tick();
        n_run++;
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_once perr=%b required 0", parity_err); end
        e1dr_async = 0;
        repeat (3) tick();
        cmd_ready = 1; tick(); cmd_ready = 0; tick();
    endtask

    task automatic test_random();
        int busy = 0;
        bit is_dr = 0;
        for (int i = 0; i < 600; i++) begin
            cmd_ready = ($urandom_range(0, 3) == 0);
            overrun_clr = ($urandom_range(0, 9) == 0);
            if (busy == 0) begin
                is_dr = ($urandom_range(0, 3) != 0);
                if (is_dr) raise_dr(38'({$urandom(), $urandom()}));
                else begin
                    ir_in = 2'($urandom_range(0, 3)); uir_async = 1; ir_edge = cyc + SS + 1;
                end
                busy = 8 + $urandom_range(0, 4);
            end else begin
                busy--;
                if (busy == 4) begin e1dr_async = 0; uir_async = 0; end
            end
            tick();
            n_run++;
            if ({cmd_valid, jdo, cmd_ch, take_action, take_no_action, overrun, parity_err} !==
                {m_valid, m_jdo, m_ch, e_act, e_nact, m_ov, e_perr}) begin
                n_fail++;
                $display("FAIL rand_%0d valid=%b jdo=%h ch=%0d act=%b nact=%b ov=%b perr=%b required %b %h %0d %b %b %b %b",
                         i, cmd_valid, jdo, cmd_ch, take_action, take_no_action, overrun, parity_err,
                         m_valid, m_jdo, m_ch, e_act, e_nact, m_ov, e_perr);
            end
            n_run++;
            if ($countones({take_action, take_no_action}) > 1) begin
                n_fail++; $display("FAIL rand_onehot_%0d pulses=%b required at most one bit", i, {take_action, take_no_action});
            end
        end
        e1dr_async = 0; uir_async = 0; cmd_ready = 0; overrun_clr = 0;
    endtask

    initial begin
        test_reset();
        test_action();
        test_no_action();
        test_overrun();
        test_aligned();
        test_reset_mid();
        test_parity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
